// File: rtl/rst_seq_if.sv
// Reset sequencer signal bundle: board button and PLL lock in, staged
// active-low channel resets and done flag out.
// Build option: define RST_SEQ_SWRST_EN to add the sw_rst_req_i request line.
interface rst_seq_if #(
  parameter int NUM_CH = 3
);
  logic              ext_rstn_i;
  logic              pll_locked_i;
  logic [NUM_CH-1:0] rstn_o;
  logic              rst_done_o;
`ifdef RST_SEQ_SWRST_EN
  logic              sw_rst_req_i;
`endif

  // Platform side: drives the reset sources, observes the channel resets.
  modport master (
`ifdef RST_SEQ_SWRST_EN
    output sw_rst_req_i,
`endif
    output ext_rstn_i,
    output pll_locked_i,
    input  rstn_o,
    input  rst_done_o
  );

  // Sequencer side.
  modport slave (
`ifdef RST_SEQ_SWRST_EN
    input  sw_rst_req_i,
`endif
    input  ext_rstn_i,
    input  pll_locked_i,
    output rstn_o,
    output rst_done_o
  );
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: synchronises and debounces the board reset button and
// PLL lock, then releases NUM_CH active-low resets in ascending order with
// STAGE_DELAY cycles between channels. Any loss of the release condition
// drops every channel at once.
// Build option: define RST_SEQ_SWRST_EN to add a one-cycle software reset
// request (sw_rst_req_i) that is ORed into the hold condition.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_RESET     | all channels held, waiting for button and lock high
// S_WAIT      | debounce window, release condition must hold throughout
// S_RELEASE   | channels released one by one, STAGE_DELAY apart
// S_RUN       | all channels released, outputs held
module rst_seq #(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STAGE_DELAY     = 8,
  parameter int NUM_CH          = 3
) (
  input  logic     clk_i,
  input  logic     rst_i,
  rst_seq_if.slave bus
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > STAGE_DELAY) ? DEBOUNCE_CYCLES : STAGE_DELAY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0] DB_TC    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ST_TC    = CW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_RESET,
    S_WAIT,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [NUM_CH-1:0]    rstn_q;
  logic                 done_q;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                 btn_s;
  logic                 lock_s;
  logic                 hold;

  // Bring the asynchronous button and lock inputs into the clk_i domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_sync  <= '0;
      lock_sync <= '0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], bus.ext_rstn_i};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked_i};
    end
  end

  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

`ifdef RST_SEQ_SWRST_EN
  assign hold = ~btn_s | ~lock_s | bus.sw_rst_req_i;
`else
  assign hold = ~btn_s | ~lock_s;
`endif

  // Sequencing FSM; hold overrides everything so a drop never releases a channel.
  always_ff @(posedge clk_i) begin
    if (rst_i || hold) begin
      state  <= S_RESET;
      cnt    <= '0;
      idx    <= '0;
      rstn_q <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state  <= S_WAIT;
          cnt    <= '0;
          idx    <= '0;
          rstn_q <= '0;
          done_q <= 1'b0;
        end
        S_WAIT: begin
          if (cnt == DB_TC) begin
            state <= S_RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt == ST_TC) begin
            cnt    <= '0;
            rstn_q <= rstn_q | (NUM_CH'(1) << idx);
            idx    <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state  <= S_RUN;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

  assign bus.rstn_o     = rstn_q;
  assign bus.rst_done_o = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default instance plus a minimal
// NUM_CH=1 / 1-cycle-delay instance. Edge numbers in comments count from
// the first posedge that samples the new input value as edge 1.
module tb_rst_seq;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  rst_seq_if #(.NUM_CH(3)) if0 ();
  rst_seq_if #(.NUM_CH(1)) if1 ();

  rst_seq #(
    .SYNC_STAGES(3), .DEBOUNCE_CYCLES(16), .STAGE_DELAY(8), .NUM_CH(3)
  ) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0)
  );

  rst_seq #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .STAGE_DELAY(1), .NUM_CH(1)
  ) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check0(input string tag, input logic [2:0] exp_rstn, input logic exp_done);
    n_checks++;
    assert (if0.rstn_o === exp_rstn) else begin
      n_fail++;
      $error("FAIL %s rstn_o: observed %b expected %b", tag, if0.rstn_o, exp_rstn);
    end
    n_checks++;
    assert (if0.rst_done_o === exp_done) else begin
      n_fail++;
      $error("FAIL %s rst_done_o: observed %b expected %b", tag, if0.rst_done_o, exp_done);
    end
  endtask

  task automatic check1(input string tag, input logic exp_rstn, input logic exp_done);
    n_checks++;
    assert (if1.rstn_o === exp_rstn) else begin
      n_fail++;
      $error("FAIL %s rstn_o: observed %b expected %b", tag, if1.rstn_o, exp_rstn);
    end
    n_checks++;
    assert (if1.rst_done_o === exp_done) else begin
      n_fail++;
      $error("FAIL %s rst_done_o: observed %b expected %b", tag, if1.rst_done_o, exp_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    if0.ext_rstn_i   = 1'b0;
    if0.pll_locked_i = 1'b1;
    if1.ext_rstn_i   = 1'b0;
    if1.pll_locked_i = 1'b0;
`ifdef RST_SEQ_SWRST_EN
    if0.sw_rst_req_i = 1'b0;
    if1.sw_rst_req_i = 1'b0;
`endif

    // Reset state
    step(2);
    check0("reset", 3'b000, 1'b0);
    check1("reset_small", 1'b0, 1'b0);
    rst = 1'b0;
    step(3);
    check0("btn_low", 3'b000, 1'b0);

    // Power-up sequence: 28 / 36 / 44
    if0.ext_rstn_i = 1'b1;
    step(20);
    check0("pwr_e20", 3'b000, 1'b0);
    step(7);
    check0("pwr_e27", 3'b000, 1'b0);
    step(1);
    check0("pwr_e28", 3'b001, 1'b0);
    step(7);
    check0("pwr_e35", 3'b001, 1'b0);
    step(1);
    check0("pwr_e36", 3'b011, 1'b0);
    step(7);
    check0("pwr_e43", 3'b011, 1'b0);
    step(1);
    check0("pwr_e44", 3'b111, 1'b1);

    // Button press in RUN: all channels drop together at edge 4
    if0.ext_rstn_i = 1'b0;
    step(3);
    check0("btn_e3", 3'b111, 1'b1);
    step(1);
    check0("btn_e4", 3'b000, 1'b0);
    step(4);

    // Glitch at edges 14-15 restarts debounce; new edge 1 is 16
    if0.ext_rstn_i = 1'b1;
    step(13);
    if0.ext_rstn_i = 1'b0;
    step(2);
    if0.ext_rstn_i = 1'b1;
    step(12);
    check0("glitch_e27", 3'b000, 1'b0);
    step(1);
    check0("glitch_e28", 3'b000, 1'b0);
    step(14);
    check0("glitch_e42", 3'b000, 1'b0);
    step(1);
    check0("glitch_e43", 3'b001, 1'b0);
    step(8);
    check0("glitch_e51", 3'b011, 1'b0);
    step(8);
    check0("glitch_e59", 3'b111, 1'b1);

    // Lock loss in RUN, then relock replays 28 / 36 / 44
    if0.pll_locked_i = 1'b0;
    step(3);
    check0("lock_e3", 3'b111, 1'b1);
    step(1);
    check0("lock_e4", 3'b000, 1'b0);
    step(4);
    if0.pll_locked_i = 1'b1;
    step(27);
    check0("relock_e27", 3'b000, 1'b0);
    step(1);
    check0("relock_e28", 3'b001, 1'b0);
    step(8);
    check0("relock_e36", 3'b011, 1'b0);
    step(7);
    check0("relock_e43", 3'b011, 1'b0);
    step(1);
    check0("relock_e44", 3'b111, 1'b1);

    // rst_i mid-RELEASE after ch0; restart from the synchronisers
    if0.ext_rstn_i = 1'b0;
    step(6);
    check0("pre_rst", 3'b000, 1'b0);
    if0.ext_rstn_i = 1'b1;
    step(28);
    check0("rst_mid_e28", 3'b001, 1'b0);
    step(3);
    rst = 1'b1;
    step(1);
    check0("rst_mid_hit", 3'b000, 1'b0);
    rst = 1'b0;
    step(27);
    check0("rst_after_e27", 3'b000, 1'b0);
    step(1);
    check0("rst_after_e28", 3'b001, 1'b0);
    step(16);
    check0("rst_after_e44", 3'b111, 1'b1);

    // Minimal instance: release and done at edge 5
    if1.ext_rstn_i   = 1'b1;
    if1.pll_locked_i = 1'b1;
    step(4);
    check1("small_e4", 1'b0, 1'b0);
    step(1);
    check1("small_e5", 1'b1, 1'b1);

`ifdef RST_SEQ_SWRST_EN
    // Software reset pulse in RUN; ch0 returns 1+16+8 edges after the drop
    if0.sw_rst_req_i = 1'b1;
    step(1);
    check0("swrst_hit", 3'b000, 1'b0);
    if0.sw_rst_req_i = 1'b0;
    step(24);
    check0("swrst_e24", 3'b000, 1'b0);
    step(1);
    check0("swrst_e25", 3'b001, 1'b0);
    step(16);
    check0("swrst_done", 3'b111, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Parametrised reset sequencer. It replaces the fixed 3-flop button synchroniser in the FPGA top wrappers.
- Synchronises and debounces the board reset button and the clock-generator lock signal.
- Releases NUM_CH active-low reset channels in ascending index order, with a programmable gap between channels (e.g. memories, then core, then peripherals).
- Sits in the top wrapper between the clock generator and the platform.

Parameters:
- SYNC_STAGES, 3: synchroniser depth for ext_rstn_i and pll_locked_i (≥2).
- DEBOUNCE_CYCLES, 16: consecutive cycles the release condition must hold before sequencing starts (≥1).
- STAGE_DELAY, 8: cycles between successive channel releases (≥1).
- NUM_CH, 3: number of reset output channels (≥1).

Ports:
- clk_i, in, 1: system clock (post clock generator).
- rst_i, in, 1: reset. One clock; reset is synchronous and active-high.
- ext_rstn_i, in, 1: board reset button, asynchronous, active-low.
- pll_locked_i, in, 1: clock generator lock, asynchronous, high = locked.
- rstn_o, out, NUM_CH: per-channel active-low resets, registered.
- rst_done_o, out, 1: high when all channels are released (state RUN), registered.

Behaviour:
- rst_i=1 (synchronous, highest priority):
  - All synchroniser flops cleared to 0.
  - State goes to RESET; counters and channel index cleared.
  - rstn_o = all 0, rst_done_o = 0.
- Synchronisers:
  - SYNC_STAGES-deep flop chains on ext_rstn_i and pll_locked_i.
  - Synced outputs btn_s and lock_s are valid after SYNC_STAGES edges.
- Definitions:
  - hold = ~btn_s | ~lock_s (registered synced values).
  - Counter widths: $clog2(max(DEBOUNCE_CYCLES, STAGE_DELAY)+1). Channel index width: $clog2(NUM_CH) (minimum 1).
- FSM states: RESET, WAIT_STABLE, RELEASE, RUN.
  - RESET:
    - rstn_o = 0, rst_done_o = 0, cnt = 0, idx = 0.
    - When hold=0, go to WAIT_STABLE.
  - WAIT_STABLE:
    - cnt increments each cycle.
    - hold=1: go to RESET (debounce restarts from 0).
    - cnt==DEBOUNCE_CYCLES-1 with hold=0: go to RELEASE, cnt←0.
  - RELEASE:
    - cnt increments each cycle.
    - When cnt==STAGE_DELAY-1: rstn_o[idx]←1, cnt←0, idx←idx+1.
    - If idx==NUM_CH-1 on that edge: go to RUN and set rst_done_o←1 on the same edge.
    - Channels already released stay at 1.
  - RUN: hold all outputs; no counters run.
- Reassertion:
  - hold=1 in any state goes to RESET on the next edge.
  - On that edge all rstn_o←0 simultaneously, rst_done_o←0, cnt and idx cleared.
  - There is no staged assertion.
- Latency, counted from the first edge that samples ext_rstn_i=1 as edge 1, with pll_locked_i already stable high:
  - FSM enters WAIT_STABLE at edge SYNC_STAGES+1.
  - FSM enters RELEASE at edge SYNC_STAGES+1+DEBOUNCE_CYCLES.
  - Channel k is released at edge SYNC_STAGES+1+DEBOUNCE_CYCLES+(k+1)*STAGE_DELAY.
  - Assertion: ext_rstn_i low sampled at edge 1 drives rstn_o low at edge SYNC_STAGES+1.
- Simultaneous events: hold=1 on the same edge as a release or the debounce terminal count means RESET wins; no channel is released.
- pll_locked_i dropping mid-sequence or in RUN is handled the same as the button.

Optional Feature:
- Macro: RST_SEQ_SWRST_EN.
- Defined:
  - Adds input sw_rst_req_i (1 bit, synchronous to clk_i, no synchroniser).
  - A high cycle is ORed into hold for that cycle: FSM goes to RESET next edge, all rstn_o←0.
  - The full debounce and release sequence then replays.
- Undefined: port absent; no software reset path.

Test Plan:
- Defaults; rst_i pulse, then ext_rstn_i=1, pll_locked_i=1 → rstn_o[0] rises at edge 28, rstn_o[1] at 36, rstn_o[2] and rst_done_o at 44; all outputs 0 before edge 28.
- ext_rstn_i glitches low for 2 cycles, 10 cycles into the debounce window → FSM returns to RESET; first release delayed by the full restart; no rstn_o bit rises early.
- In RUN, pll_locked_i→0 → all three rstn_o and rst_done_o go 0 together 4 edges later; re-lock → full sequence replays with the same 28/36/44 offsets.
- rst_i=1 asserted mid-RELEASE (after ch0 released) → next edge rstn_o=3'b000, rst_done_o=0; after rst_i deasserts, the sequence restarts from the synchroniser.
- NUM_CH=1, DEBOUNCE_CYCLES=1, STAGE_DELAY=1, SYNC_STAGES=2 → rstn_o[0] and rst_done_o rise at edge 5.
- With RST_SEQ_SWRST_EN: one-cycle sw_rst_req_i in RUN → rstn_o=0 next edge; re-release of ch0 occurs 1+DEBOUNCE_CYCLES+STAGE_DELAY edges later.
